// File: rtl/popcount_block_ctrl.sv
// Ones-count sequencer: accepts a job of LEN words over a valid/ready stream
// and accumulates the number of set bits into a saturating total.
module popcount_block_ctrl #(
  parameter int unsigned IN_WIDTH  = 8,
  parameter int unsigned CNT_WIDTH = 4,
  parameter int unsigned LEN_WIDTH = 8,
  parameter int unsigned ACC_WIDTH = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] len,
  output logic                 busy,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [ACC_WIDTH-1:0] total,
  output logic                 done,
  output logic                 overflow
);

  localparam int unsigned SumWidth = ACC_WIDTH + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e               state_q, state_d;
  logic [LEN_WIDTH-1:0] remaining_q, remaining_d;
  logic [ACC_WIDTH-1:0] total_q, total_d;
  logic                 overflow_q, overflow_d;

  logic [CNT_WIDTH-1:0] ones;
  logic [SumWidth-1:0]  sum;

  // Combinational ones counter for the current input word.
  always_comb begin
    ones = '0;
    for (int i = 0; i < IN_WIDTH; i++) begin
      ones = ones + CNT_WIDTH'(in_data[i]);
    end
  end

  // One extra bit so the carry out flags saturation.
  assign sum = {1'b0, total_q} + SumWidth'(ones);

  // Next-state logic for FSM, word counter and accumulator.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    total_d     = total_q;
    overflow_d  = overflow_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          total_d     = '0;
          overflow_d  = 1'b0;
          remaining_d = len;
          state_d     = (len != '0) ? StRun : StDone;
        end
      end
      StRun: begin
        if (in_valid) begin
          if (remaining_q != '0) begin
            remaining_d = remaining_q - LEN_WIDTH'(1);
          end
          if (sum[ACC_WIDTH]) begin
            total_d    = '1;
            overflow_d = 1'b1;
          end else begin
            total_d = sum[ACC_WIDTH-1:0];
          end
          if (remaining_q == LEN_WIDTH'(1)) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      total_q     <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      total_q     <= total_d;
      overflow_q  <= overflow_d;
    end
  end

  // Outputs decode from state only; in_ready never looks at in_valid.
  assign busy     = (state_q != StIdle);
  assign in_ready = (state_q == StRun);
  assign done     = (state_q == StDone);
  assign total    = total_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_popcount_block_ctrl.sv
// Bench for popcount_block_ctrl: two instances (12-bit and 4-bit accumulator)
// share one stimulus stream; a scoreboard queue holds expected job results.
module tb_popcount_block_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  len;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        busy_a, ready_a, done_a, ovf_a;
  logic [11:0] total_a;
  logic        busy_b, ready_b, done_b, ovf_b;
  logic [3:0]  total_b;

  popcount_block_ctrl #(
    .IN_WIDTH (8),
    .CNT_WIDTH(4),
    .LEN_WIDTH(8),
    .ACC_WIDTH(12)
  ) u_dut_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .len     (len),
    .busy    (busy_a),
    .in_data (in_data),
    .in_valid(in_valid),
    .in_ready(ready_a),
    .total   (total_a),
    .done    (done_a),
    .overflow(ovf_a)
  );

  popcount_block_ctrl #(
    .IN_WIDTH (8),
    .CNT_WIDTH(4),
    .LEN_WIDTH(8),
    .ACC_WIDTH(4)
  ) u_dut_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .len     (len),
    .busy    (busy_b),
    .in_data (in_data),
    .in_valid(in_valid),
    .in_ready(ready_b),
    .total   (total_b),
    .done    (done_b),
    .overflow(ovf_b)
  );

  typedef struct {
    int len;
    int t12;
    bit o12;
    int t4;
    bit o4;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] jw[$];
  int         n_chk = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         last_t12 = 0, last_t4 = 0;
  bit         last_o12 = 0, last_o4 = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: running sum of set bits, clipped at the width's maximum.
  task automatic model(input int accw, output int t, output bit o);
    int mx;
    mx = (1 << accw) - 1;
    t  = 0;
    o  = 1'b0;
    foreach (jw[i]) begin
      t += $countones(jw[i]);
      if (t > mx) begin
        t = mx;
        o = 1'b1;
      end
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy_a && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (busy_a) chk("idle_timeout", 32'(busy_a), 32'd0);
  endtask

  // Called in IDLE, #1 after an edge. Checks the previous result was held.
  task automatic issue_start(input int l, input bit junk_valid);
    exp_t e;
    chk("hold_total12", 32'(total_a), 32'(last_t12));
    chk("hold_ovf12", 32'(ovf_a), 32'(last_o12));
    chk("hold_total4", 32'(total_b), 32'(last_t4));
    chk("hold_ovf4", 32'(ovf_b), 32'(last_o4));
    e.len = l;
    model(12, e.t12, e.o12);
    model(4, e.t4, e.o4);
    sb.push_back(e);
    last_t12 = e.t12;
    last_o12 = e.o12;
    last_t4  = e.t4;
    last_o4  = e.o4;
    start    = 1'b1;
    len      = 8'(l);
    in_valid = junk_valid;
    in_data  = 8'($urandom);
  endtask

  // Present the first n words of jw; mode 0 continuous, 1 toggling, 2 random gaps.
  task automatic feed(input int n, input int mode);
    for (int k = 0; k < n; k++) begin
      int gaps;
      bit r;
      int w;
      gaps = (mode == 1 && k > 0) ? 1 : (mode == 2) ? $urandom_range(0, 2) : 0;
      for (int g = 0; g < gaps; g++) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        @(posedge clk);
        #1;
      end
      in_valid = 1'b1;
      in_data  = jw[k];
      w = 0;
      r = 1'b0;
      while (!r && w < 50) begin
        r = ready_a;
        @(posedge clk);
        #1;
        w++;
      end
      if (!r) chk("ready_timeout", 32'(r), 32'd1);
    end
    in_valid = (mode == 2) ? 1'($urandom) : 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic run_job(input int mode);
    wait_idle();
    issue_start(jw.size(), mode == 2);
    @(posedge clk);
    #1;
    start = 1'b0;
    feed(jw.size(), mode);
    wait_idle();
  endtask

  // Monitor: tracks accepted start/beats and checks each done pulse.
  int mon_last_ev = 0;
  int mon_beats = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_beats = 0;
    end else begin
      if (!busy_a && start) begin
        mon_last_ev = cyc;
        mon_beats   = 0;
      end
      if (in_valid && ready_a) begin
        mon_last_ev = cyc;
        mon_beats++;
      end
      if (!busy_a || done_a) chk("ready_outside_run", 32'(ready_a), 32'd0);
      if (done_a || done_b) begin
        chk("done_pair", 32'(done_b), 32'(done_a));
        chk("ready_pair", 32'(ready_b), 32'(ready_a));
        if (sb.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_done: got done with no job pending (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("total12", 32'(total_a), 32'(e.t12));
          chk("ovf12", 32'(ovf_a), 32'(e.o12));
          chk("total4", 32'(total_b), 32'(e.t4));
          chk("ovf4", 32'(ovf_b), 32'(e.o4));
          chk("beats", 32'(mon_beats), 32'(e.len));
          chk("done_latency", 32'(cyc), 32'(mon_last_ev + 1));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    len      = 8'd0;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_ready", 32'(ready_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_total", 32'(total_a), 32'd0);
    chk("rst_ovf", 32'(ovf_a), 32'd0);
    chk("rst_total4", 32'(total_b), 32'd0);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;

    // Directed: basic job, zero length, toggled valid, saturation pair.
    jw = '{8'hFF, 8'h0F, 8'h01};
    run_job(0);
    jw.delete();
    run_job(0);
    jw = '{8'hAA, 8'hAA, 8'hAA, 8'hAA};
    run_job(1);
    jw = '{8'hFF, 8'hFF, 8'hFF};
    run_job(0);
    jw = '{8'h01};
    run_job(0);

    // Reset mid-job after 2 of 5 words: abort, no done.
    jw = '{8'hFF, 8'h7F, 8'h3F, 8'h1F, 8'h0F};
    wait_idle();
    issue_start(5, 1'b0);
    @(posedge clk);
    #1;
    start = 1'b0;
    feed(2, 0);
    rst_n = 1'b0;
    #1;
    void'(sb.pop_back());
    last_t12 = 0;
    last_o12 = 0;
    last_t4  = 0;
    last_o4  = 0;
    chk("abort_busy", 32'(busy_a), 32'd0);
    chk("abort_total", 32'(total_a), 32'd0);
    chk("abort_total4", 32'(total_b), 32'd0);
    chk("abort_ovf4", 32'(ovf_b), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    jw = '{8'h80};
    run_job(0);

    // start held high: second job begins only after DONE -> IDLE.
    jw = '{8'h03, 8'h03};
    wait_idle();
    issue_start(2, 1'b0);
    @(posedge clk);
    #1;
    feed(2, 0);
    chk("held_start_done", 32'(done_a), 32'd1);
    @(posedge clk);
    #1;
    chk("held_start_idle", 32'(busy_a), 32'd0);
    issue_start(2, 1'b0);
    @(posedge clk);
    #1;
    start = 1'b0;
    feed(2, 0);
    wait_idle();

    // Maximum job length.
    jw.delete();
    for (int i = 0; i < 255; i++) jw.push_back(8'hFF);
    run_job(0);

    // Randomized jobs.
    for (int j = 0; j < 30; j++) begin
      int l;
      jw.delete();
      l = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 12);
      for (int i = 0; i < l; i++) begin
        jw.push_back(($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom));
      end
      run_job($urandom_range(0, 2));
    end

    repeat (3) @(posedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
